// File: rtl/rx_fifo_if.sv
// rx_fifo_if -- bundle of the UART-side and consumer-side signals of rx_fifo.
//
//   UART side     : rx_data, valid, brk  (to FIFO), rd (from FIFO)
//   Consumer side : out_rd (to FIFO), out_data, out_valid, count, full (from FIFO)
//
// The line-break indication is named brk because "break" is a reserved
// keyword in SystemVerilog and cannot be used as a plain identifier.
//
// Modports:
//   slave  - the FIFO itself
//   master - the environment (UART + consumer) driving the FIFO
interface rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]            rx_data;
    logic                  valid;
    logic                  brk;
    logic                  rd;
    logic [7:0]            out_data;
    logic                  out_valid;
    logic                  out_rd;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;

    modport slave (
        input  rx_data, valid, brk, out_rd,
        output rd, out_data, out_valid, count, full
    );

    modport master (
        output rx_data, valid, brk, out_rd,
        input  rd, out_data, out_valid, count, full
    );
endinterface

// File: rtl/rx_fifo.sv
// rx_fifo -- receive FIFO between a UART and a byte consumer.
//
// A two-state input handshake (IDLE/WAIT) captures one byte per UART
// "valid" assertion and acknowledges it with a single-cycle rd pulse. The
// UART must drop valid before the next byte is accepted, so a byte that is
// held on valid is never written twice. When full, the byte is left pending
// at the UART (no rd) until a slot frees up.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - rx_fifo_if.slave: rx_data/valid/brk/rd toward the UART,
//            out_data/out_valid/out_rd/count/full toward the consumer
//
// Configuration:
//   RX_FIFO_BREAK_FLUSH_EN - when defined, brk=1 flushes the FIFO at the
//   clock edge (pointers, count cleared, handshake back to IDLE, any push or
//   pop in that cycle dropped). When undefined, brk is ignored.
module rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    rx_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]            state;
    logic                  rd_q;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic [7:0]            mem [DEPTH];

    logic full_w;
    logic empty_w;
    logic flush;
    logic push;
    logic pop;

`ifdef RX_FIFO_BREAK_FLUSH_EN
    assign flush = bus.brk;
`else
    // brk stays on the interface but has no effect in this build.
    logic unused_brk;
    assign unused_brk = bus.brk;
    assign flush      = 1'b0;
`endif

    assign full_w  = (cnt == CNT_FULL);
    assign empty_w = (cnt == '0);

    // full is registered state, so a pop while full frees the slot at this
    // edge and the pending byte is captured on the following one.
    assign push = (state == S_IDLE) && bus.valid && !full_w && !flush;
    assign pop  = bus.out_rd && !empty_w && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rd_q   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            state  <= S_IDLE;
            rd_q   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rd_q <= push;
                    if (push) state <= S_WAIT;
                end
                S_WAIT: begin
                    rd_q <= 1'b0;
                    // Hold here until the UART releases valid.
                    if (!bus.valid) state <= S_IDLE;
                end
                default: begin
                    rd_q  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is deliberately not reset; out_data is only meaningful while
    // out_valid is high.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rx_data;
    end

    assign bus.rd        = rd_q;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_valid = !empty_w;
    assign bus.count     = cnt;
    assign bus.full      = full_w;
endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of FIFO entries (DEPTH = 16).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx_data  input  8  received byte from the UART.
REQ-005 SHALL have port valid  input  1  UART has a byte pending.
REQ-006 SHALL have port break  input  1  UART line-break indication.
REQ-007 SHALL have port rd  output  1  one-cycle acknowledge to the UART.
REQ-008 SHALL have port out_data  output  8  byte at FIFO head.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_rd  input  1  consumer pop request.
REQ-011 SHALL have port count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port full  output  1  count == DEPTH.

Function
REQ-013 SHALL run an input state machine with two states, IDLE and WAIT.
REQ-014 In IDLE with valid=1 and full=0, SHALL write rx_data at wr_ptr, increment wr_ptr, register rd=1 and go to WAIT.
REQ-015 In IDLE with valid=1 and full=1, SHALL not write, keep rd=0 and stay in IDLE (backpressure, no data loss inside the block).
REQ-016 In WAIT, SHALL register rd=0 and return to IDLE only once valid=0, so a byte is never captured twice.
REQ-017 rd SHALL be high for exactly one clock per captured byte.
REQ-018 out_valid SHALL equal (count != 0); out_data SHALL equal mem[rd_ptr], both with zero-cycle latency from state.
REQ-019 out_rd=1 with out_valid=1 SHALL pop one entry at the clock edge; out_rd while empty SHALL be ignored.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push while full is impossible by REQ-015, so a pop while full still frees exactly one slot.
REQ-021 wr_ptr and rd_ptr SHALL be DEPTH_LOG2 bits wide and wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-022 First-written byte SHALL be the first presented on out_data (strict FIFO order).

Reset
REQ-023 rst_n=0 SHALL immediately force: state=IDLE, rd=0, wr_ptr=0, rd_ptr=0, count=0, out_valid=0, full=0.
REQ-024 Storage array contents SHALL not be reset; out_data is don't-care while out_valid=0.
REQ-025 Reset asserted during WAIT SHALL abandon the handshake; after release, a still-high valid SHALL be captured as a new byte.

Configuration
REQ-026 Macro RX_FIFO_BREAK_FLUSH_EN defined: break=1 SHALL, at the clock edge, clear wr_ptr, rd_ptr, count and force state to IDLE, discarding stored and in-flight bytes; push and pop in that cycle SHALL be ignored.
REQ-027 Macro RX_FIFO_BREAK_FLUSH_EN undefined: break SHALL be ignored entirely; the port SHALL remain present.

Verification
REQ-028 After reset, UART presents "K","S","O" one at a time -> rd pulses once each; count goes 1,2,3; out_data="K" with out_valid=1.
REQ-029 Pop three times with out_rd held 1 -> out_data sequence "K","S","O"; count reaches 0, out_valid=0; a fourth out_rd leaves count=0.
REQ-030 Push 16 bytes 0x00..0x0F with no pops -> full=1, count=16; a 17th byte 0x10 held on valid gets no rd; one pop -> 0x10 is acknowledged and stored, and the read order is 0x01..0x10.
REQ-031 With count=5, push and pop on the same edge -> count stays 5; byte order is preserved across a pointer wrap (write 20 bytes, pop as they arrive).
REQ-032 valid held high for 4 cycles after a single rd pulse -> exactly one entry written.
REQ-033 With count=3, assert break for one cycle (macro defined) -> count=0, out_valid=0; without the macro -> count stays 3; assert rst_n=0 mid-WAIT -> all outputs at reset values the same cycle.
